arp_rx: RTL and testbench

- GMII receive-side ARP parser. It is the counterpart to the ARP request transmitter on the SGMII/PCS-PMA path.
- Sits on the PCS/PMA GMII RX bus, in the userclk2 domain.
- Strips preamble/SFD, filters on destination MAC, EtherType and target IP, and checks the FCS.
- Reports each valid ARP request or reply with the sender's MAC and IP. The reply/cache logic consumes these results.

---
 rtl/arp_rx_if.sv | 21 ++
 rtl/arp_rx.sv | 224 ++++++++++++++++++++++
 tb/tb_arp_rx.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/arp_rx_if.sv
// GMII receive bus and parsed ARP result shared by the arp_rx parser and its consumers.
// master drives the GMII side and observes results; slave is the parser itself.
interface arp_rx_if;
    logic [7:0]  gmii_rx_data;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic        arp_rx_done;
    logic        arp_rx_type;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic        crc_err;

    modport master (
        output gmii_rx_data, gmii_rx_dv, gmii_rx_er,
        input  arp_rx_done, arp_rx_type, src_mac, src_ip, crc_err
    );
    modport slave (
        input  gmii_rx_data, gmii_rx_dv, gmii_rx_er,
        output arp_rx_done, arp_rx_type, src_mac, src_ip, crc_err
    );
endinterface

// File: rtl/arp_rx.sv
// GMII receive-side ARP parser: strips preamble/SFD, filters DA/EtherType/target IP,
// checks the FCS and reports sender MAC/IP of each accepted ARP request or reply.
module arp_rx #(
    parameter logic [47:0] LOCAL_MAC = 48'h000A3501FEC0,
    parameter logic [31:0] LOCAL_IP  = 32'hC0A80002,
    parameter int          MAX_FRAME = 1518
) (
    input  logic    gmii_clk,
    input  logic    sys_rst_n,
    arp_rx_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PREAMBLE, HDR, ARP, TRAIL, DROP} state_t;

    localparam logic [10:0] LAST_IDX    = 11'(MAX_FRAME - 1);
    localparam logic [10:0] MIN_LEN     = 11'd64;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    state_t      r_state, w_next;
    logic [3:0]  r_pre_cnt;
    logic [10:0] r_idx;
    logic [31:0] r_crc;
    logic        r_armed;
    logic        r_bc, r_uc;
    logic        r_sh_type;
    logic [47:0] r_sh_mac;
    logic [31:0] r_sh_ip;
    logic        r_done, r_type, r_crc_err;
    logic [47:0] r_mac;
    logic [31:0] r_ip;

    logic [7:0]  w_data;
    logic        w_dv, w_er;
    logic [7:0]  w_mac_byte, w_ip_byte;
    logic        w_bc, w_uc, w_hdr_ok, w_arp_ok;
    logic        w_pre_load, w_pre_inc, w_start, w_take, w_fin;
    logic        w_done, w_crc_bad;

    assign w_data = bus.gmii_rx_data;
    assign w_dv   = bus.gmii_rx_dv;
    assign w_er   = bus.gmii_rx_er;

    assign bus.arp_rx_done = r_done;
    assign bus.arp_rx_type = r_type;
    assign bus.src_mac     = r_mac;
    assign bus.src_ip      = r_ip;
    assign bus.crc_err     = r_crc_err;

    // Reflected CRC-32, one byte per call, LSB of the byte first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] x;
        x = c;
        for (int i = 0; i < 8; i++)
            x = (x[0] ^ d[i]) ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
        return x;
    endfunction

    // Expected byte of LOCAL_MAC / LOCAL_IP for the current index, wire order.
    always_comb begin
        w_mac_byte = 8'h00;
        case (r_idx[2:0])
            3'd0:    w_mac_byte = LOCAL_MAC[47:40];
            3'd1:    w_mac_byte = LOCAL_MAC[39:32];
            3'd2:    w_mac_byte = LOCAL_MAC[31:24];
            3'd3:    w_mac_byte = LOCAL_MAC[23:16];
            3'd4:    w_mac_byte = LOCAL_MAC[15:8];
            3'd5:    w_mac_byte = LOCAL_MAC[7:0];
            default: w_mac_byte = 8'h00;
        endcase
        w_ip_byte = 8'h00;
        case (r_idx[1:0])
            2'd2:    w_ip_byte = LOCAL_IP[31:24];
            2'd3:    w_ip_byte = LOCAL_IP[23:16];
            2'd0:    w_ip_byte = LOCAL_IP[15:8];
            default: w_ip_byte = LOCAL_IP[7:0];
        endcase
    end

    // DA may be broadcast or our MAC; both candidates are tracked across bytes 0-5.
    always_comb begin
        w_bc     = ((r_idx == 11'd0) | r_bc) & (w_data == 8'hFF);
        w_uc     = ((r_idx == 11'd0) | r_uc) & (w_data == w_mac_byte);
        w_hdr_ok = 1'b1;
        case (r_idx)
            11'd0, 11'd1, 11'd2,
            11'd3, 11'd4, 11'd5: w_hdr_ok = w_bc | w_uc;
            11'd12:              w_hdr_ok = (w_data == 8'h08);
            11'd13:              w_hdr_ok = (w_data == 8'h06);
            default:             w_hdr_ok = 1'b1;
        endcase
        w_arp_ok = 1'b1;
        case (r_idx)
            11'd14, 11'd17, 11'd20: w_arp_ok = (w_data == 8'h00);
            11'd15:                 w_arp_ok = (w_data == 8'h01);
            11'd16:                 w_arp_ok = (w_data == 8'h08);
            11'd18:                 w_arp_ok = (w_data == 8'h06);
            11'd19:                 w_arp_ok = (w_data == 8'h04);
            11'd21:                 w_arp_ok = (w_data == 8'h01) || (w_data == 8'h02);
            11'd38, 11'd39,
            11'd40, 11'd41:         w_arp_ok = (w_data == w_ip_byte);
            default:                w_arp_ok = 1'b1;
        endcase
    end

    always_ff @(posedge gmii_clk) begin
        if (!sys_rst_n) r_state <= IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_pre_load = 1'b0;
        w_pre_inc  = 1'b0;
        w_start    = 1'b0;
        w_take     = 1'b0;
        w_fin      = 1'b0;
        case (r_state)
            IDLE: begin
                // After reset, a frame already in flight is ignored until dv drops.
                if (r_armed && w_dv) begin
                    if (w_data == 8'h55) begin
                        w_next     = PREAMBLE;
                        w_pre_load = 1'b1;
                    end else begin
                        w_next = DROP;
                    end
                end
            end
            PREAMBLE: begin
                if (!w_dv)                   w_next = IDLE;
                else if (w_er)               w_next = DROP;
                else if (w_data == 8'h55) begin
                    if (r_pre_cnt >= 4'd7)   w_next = DROP;
                    else                     w_pre_inc = 1'b1;
                end else if (w_data == 8'hD5 && r_pre_cnt != 4'd0) begin
                    w_next  = HDR;
                    w_start = 1'b1;
                end else                     w_next = DROP;
            end
            HDR: begin
                if (!w_dv)                   w_next = IDLE;
                else if (w_er || !w_hdr_ok)  w_next = DROP;
                else begin
                    w_take = 1'b1;
                    if (r_idx == 11'd13) w_next = ARP;
                end
            end
            ARP: begin
                if (!w_dv)                   w_next = IDLE;
                else if (w_er || !w_arp_ok)  w_next = DROP;
                else begin
                    w_take = 1'b1;
                    if (r_idx == 11'd41) w_next = TRAIL;
                end
            end
            TRAIL: begin
                if (!w_dv) begin
                    w_next = IDLE;
                    w_fin  = 1'b1;
                end else if (w_er || r_idx > LAST_IDX) begin
                    w_next = DROP;
                end else begin
                    w_take = 1'b1;
                end
            end
            DROP:    if (!w_dv) w_next = IDLE;
            default: w_next = IDLE;
        endcase
        // r_idx equals the byte count here, FCS included.
        w_done    = w_fin && (r_idx >= MIN_LEN) && (r_crc == CRC_RESIDUE);
        w_crc_bad = w_fin && (r_idx >= MIN_LEN) && (r_crc != CRC_RESIDUE);
    end

    always_ff @(posedge gmii_clk) begin
        if (!sys_rst_n) begin
            r_armed   <= 1'b0;
            r_pre_cnt <= 4'd0;
            r_idx     <= 11'd0;
            r_crc     <= 32'hFFFFFFFF;
            r_bc      <= 1'b0;
            r_uc      <= 1'b0;
            r_sh_type <= 1'b0;
            r_sh_mac  <= 48'd0;
            r_sh_ip   <= 32'd0;
            r_done    <= 1'b0;
            r_crc_err <= 1'b0;
            r_type    <= 1'b0;
            r_mac     <= 48'd0;
            r_ip      <= 32'd0;
        end else begin
            if (!w_dv) r_armed <= 1'b1;

            if (w_pre_load)     r_pre_cnt <= 4'd1;
            else if (w_pre_inc) r_pre_cnt <= r_pre_cnt + 4'd1;

            if (w_start) begin
                r_idx <= 11'd0;
                r_crc <= 32'hFFFFFFFF;
            end else if (w_take) begin
                r_crc <= crc_byte(r_crc, w_data);
                if (r_idx != 11'h7FF) r_idx <= r_idx + 11'd1;
            end

            if (w_take && r_idx < 11'd6) begin
                r_bc <= w_bc;
                r_uc <= w_uc;
            end
            // Sender fields go to shadows so a later-rejected frame never disturbs outputs.
            if (w_take && r_idx == 11'd21)
                r_sh_type <= w_data[1];
            if (w_take && r_idx >= 11'd22 && r_idx <= 11'd27)
                r_sh_mac <= {r_sh_mac[39:0], w_data};
            if (w_take && r_idx >= 11'd28 && r_idx <= 11'd31)
                r_sh_ip <= {r_sh_ip[23:0], w_data};

            r_done    <= w_done;
            r_crc_err <= w_crc_bad;
            if (w_done) begin
                r_type <= r_sh_type;
                r_mac  <= r_sh_mac;
                r_ip   <= r_sh_ip;
            end
        end
    end
endmodule

// File: tb/tb_arp_rx.sv
// Directed bench for arp_rx: frames are built with their FCS, expected pulses are queued
// at issue time and a negedge monitor pops and compares whenever a pulse appears.
module tb_arp_rx;
    localparam logic [47:0] LMAC  = 48'h000A3501FEC0;
    localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
    localparam int          NONE  = 9999;

    typedef struct {
        logic        is_done;
        logic        typ;
        logic [47:0] mac;
        logic [31:0] ip;
    } exp_t;

    logic gmii_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    arp_rx_if bus();

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    logic [7:0] frm[$];
    logic        h_type;
    logic [47:0] h_mac;
    logic [31:0] h_ip;

    arp_rx dut (.gmii_clk(gmii_clk), .sys_rst_n(sys_rst_n), .bus(bus));

    always #4 gmii_clk = ~gmii_clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endfunction

    task automatic build(input logic [47:0] da, input logic [15:0] et, input logic [15:0] op,
                         input logic [47:0] sm, input logic [31:0] sip, input logic [31:0] tip,
                         input int pad);
        logic [31:0] c;
        frm.delete();
        for (int i = 5; i >= 0; i--) frm.push_back(da[8*i +: 8]);
        for (int i = 5; i >= 0; i--) frm.push_back(sm[8*i +: 8]);
        frm.push_back(et[15:8]); frm.push_back(et[7:0]);
        frm.push_back(8'h00); frm.push_back(8'h01);
        frm.push_back(8'h08); frm.push_back(8'h00);
        frm.push_back(8'h06); frm.push_back(8'h04);
        frm.push_back(op[15:8]); frm.push_back(op[7:0]);
        for (int i = 5; i >= 0; i--) frm.push_back(sm[8*i +: 8]);
        for (int i = 3; i >= 0; i--) frm.push_back(sip[8*i +: 8]);
        for (int i = 0; i < 6; i++)  frm.push_back(8'h00);
        for (int i = 3; i >= 0; i--) frm.push_back(tip[8*i +: 8]);
        for (int i = 0; i < pad; i++) frm.push_back(8'h00);
        c = 32'hFFFFFFFF;
        foreach (frm[k])
            for (int b = 0; b < 8; b++)
                c = (c[0] ^ frm[k][b]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        c = ~c;
        for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
    endtask

    task automatic send(input int trunc, input int er_at, input int rst_at);
        int n;
        n = (trunc > 0) ? trunc : frm.size();
        for (int i = 0; i < 8; i++) begin
            @(posedge gmii_clk); #1;
            bus.gmii_rx_dv   = 1'b1;
            bus.gmii_rx_er   = 1'b0;
            bus.gmii_rx_data = (i == 7) ? 8'hD5 : 8'h55;
        end
        for (int i = 0; i < n; i++) begin
            @(posedge gmii_clk); #1;
            bus.gmii_rx_data = frm[i];
            bus.gmii_rx_er   = (i == er_at);
            sys_rst_n        = !(i >= rst_at && i < rst_at + 3);
        end
        @(posedge gmii_clk); #1;
        bus.gmii_rx_dv   = 1'b0;
        bus.gmii_rx_er   = 1'b0;
        bus.gmii_rx_data = 8'h00;
        sys_rst_n        = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge gmii_clk);
        #1;
    endtask

    task automatic expect_done(input logic typ, input logic [47:0] mac, input logic [31:0] ip);
        exp_t e;
        e.is_done = 1'b1; e.typ = typ; e.mac = mac; e.ip = ip;
        sb.push_back(e);
        h_type = typ; h_mac = mac; h_ip = ip;
    endtask

    task automatic expect_crc_err();
        exp_t e;
        e.is_done = 1'b0; e.typ = 1'b0; e.mac = 48'd0; e.ip = 32'd0;
        sb.push_back(e);
    endtask

    task automatic check_hold(input string tag);
        @(negedge gmii_clk);
        chk({tag, "_type"}, 64'(bus.arp_rx_type), 64'(h_type));
        chk({tag, "_mac"},  64'(bus.src_mac),     64'(h_mac));
        chk({tag, "_ip"},   64'(bus.src_ip),      64'(h_ip));
        chk({tag, "_pending"}, 64'(sb.size()),    64'd0);
    endtask

    // Monitor: every pulse must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge gmii_clk);
            if (bus.arp_rx_done || bus.crc_err) begin
                chk("pulse_exclusive", 64'(bus.arp_rx_done & bus.crc_err), 64'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse got done=%b crc_err=%b want none",
                             bus.arp_rx_done, bus.crc_err);
                end else begin
                    e = sb.pop_front();
                    chk("pulse_kind", 64'(bus.arp_rx_done), 64'(e.is_done));
                    if (e.is_done) begin
                        chk("done_type", 64'(bus.arp_rx_type), 64'(e.typ));
                        chk("done_mac",  64'(bus.src_mac),     64'(e.mac));
                        chk("done_ip",   64'(bus.src_ip),      64'(e.ip));
                    end
                end
            end
        end
    end

    initial begin
        bus.gmii_rx_data = 8'h00;
        bus.gmii_rx_dv   = 1'b0;
        bus.gmii_rx_er   = 1'b0;
        h_type = 1'b0; h_mac = 48'd0; h_ip = 32'd0;
        idle(4);
        @(negedge gmii_clk);
        chk("rst_done",    64'(bus.arp_rx_done), 64'd0);
        chk("rst_crc_err", 64'(bus.crc_err),     64'd0);
        check_hold("rst");
        sys_rst_n = 1'b1;
        idle(3);

        // Request then reply, reply preamble starting on the request's done cycle.
        build(BCAST, 16'h0806, 16'h0001, 48'h001122334455, 32'hC0A80003, 32'hC0A80002, 18);
        expect_done(1'b0, 48'h001122334455, 32'hC0A80003);
        send(0, NONE, NONE);
        build(LMAC, 16'h0806, 16'h0002, 48'h02AABBCCDDEE, 32'hC0A80001, 32'hC0A80002, 18);
        expect_done(1'b1, 48'h02AABBCCDDEE, 32'hC0A80001);
        send(0, NONE, NONE);
        idle(5);
        check_hold("reply");

        // Filtered frames: wrong EtherType, foreign DA, wrong target IP.
        build(BCAST, 16'h0800, 16'h0001, 48'h001122334455, 32'hC0A80003, 32'hC0A80002, 18);
        send(0, NONE, NONE);
        idle(2);
        build(48'h000000000001, 16'h0806, 16'h0001, 48'h001122334455, 32'hC0A80003, 32'hC0A80002, 18);
        send(0, NONE, NONE);
        idle(2);
        build(BCAST, 16'h0806, 16'h0001, 48'h001122334455, 32'hC0A80003, 32'hC0A80009, 18);
        send(0, NONE, NONE);
        idle(5);
        check_hold("filter");

        // Bad FCS: last FCS byte flipped in bit 0.
        build(BCAST, 16'h0806, 16'h0001, 48'h0011223344AA, 32'hC0A80005, 32'hC0A80002, 18);
        frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h01;
        expect_crc_err();
        send(0, NONE, NONE);
        idle(5);
        check_hold("badfcs");

        // er on byte 20, then a 50-byte runt, then an immediate valid request.
        build(BCAST, 16'h0806, 16'h0001, 48'h001122334455, 32'hC0A80003, 32'hC0A80002, 18);
        send(0, 20, NONE);
        send(50, NONE, NONE);
        build(BCAST, 16'h0806, 16'h0001, 48'h001122334477, 32'hC0A80004, 32'hC0A80002, 18);
        expect_done(1'b0, 48'h001122334477, 32'hC0A80004);
        send(0, NONE, NONE);
        idle(5);
        check_hold("after_runt");

        // Reset for 3 cycles at byte 30, released while dv is still high.
        build(BCAST, 16'h0806, 16'h0001, 48'h001122334455, 32'hC0A80003, 32'hC0A80002, 18);
        h_type = 1'b0; h_mac = 48'd0; h_ip = 32'd0;
        send(0, NONE, 30);
        idle(5);
        check_hold("midrst");
        build(LMAC, 16'h0806, 16'h0002, 48'h00DEADBEEF01, 32'hC0A80007, 32'hC0A80002, 18);
        expect_done(1'b1, 48'h00DEADBEEF01, 32'hC0A80007);
        send(0, NONE, NONE);
        idle(5);
        check_hold("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
